// File: rtl/elevator_pkg.sv
// Shared encodings for the single-car elevator controller.
package elevator_pkg;

  // Motor command encodings.
  localparam logic [1:0] AC_STOP = 2'b00;
  localparam logic [1:0] AC_UP   = 2'b10;
  localparam logic [1:0] AC_DOWN = 2'b01;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Floor index width; never narrower than one bit.
  function automatic int floor_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elevator_req_bank.sv
// Per-floor call latches (car, hall up, hall down) plus the positional
// summaries the scheduler needs: calls above/below/at the car, and calls
// beyond the neighbouring floors for the stop decision.
module elevator_req_bank
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 3,
  parameter int FW         = floor_w(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic [NUM_FLOORS-1:0] hall_up,
  input  logic [NUM_FLOORS-1:0] hall_dn,
  input  logic [FW-1:0]         pos,
  input  logic                  door_open,
  input  logic [NUM_FLOORS-1:0] clr_car,
  input  logic [NUM_FLOORS-1:0] clr_up,
  input  logic [NUM_FLOORS-1:0] clr_dn,
  output logic [NUM_FLOORS-1:0] car_q,
  output logic [NUM_FLOORS-1:0] up_q,
  output logic [NUM_FLOORS-1:0] dn_q,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  above,
  output logic                  below,
  output logic                  here,
  output logic                  above_nxt,
  output logic                  below_nxt,
  output logic                  press_here
);

  // Top landing has no up button, bottom landing has no down button.
  localparam logic [NUM_FLOORS-1:0] UP_OK = ~(NUM_FLOORS'(1) << (NUM_FLOORS - 1));
  localparam logic [NUM_FLOORS-1:0] DN_OK = ~NUM_FLOORS'(1);

  logic [NUM_FLOORS-1:0] at_pos, hold, up_in, dn_in;

  assign at_pos     = NUM_FLOORS'(1) << pos;
  assign up_in      = hall_up & UP_OK;
  assign dn_in      = hall_dn & DN_OK;
  // While the door is open, presses at the current landing are swallowed
  // (they only extend the door time) so they never re-arm a call.
  assign hold       = door_open ? at_pos : '0;
  assign press_here = |((car_req | up_in | dn_in) & hold);
  assign pending    = car_q | up_q | dn_q;
  assign here       = |(pending & at_pos);

  // Call latches: a press sets, a clear resets, a press beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_q <= '0;
      up_q  <= '0;
      dn_q  <= '0;
    end else begin
      car_q <= (car_req & ~hold) | (car_q & ~clr_car);
      up_q  <= (up_in   & ~hold) | (up_q  & ~clr_up);
      dn_q  <= (dn_in   & ~hold) | (dn_q  & ~clr_dn);
    end
  end

  // Positional summaries relative to pos and to pos+/-1.
  always_comb begin
    above     = 1'b0;
    below     = 1'b0;
    above_nxt = 1'b0;
    below_nxt = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(pos))     above     = above     | pending[i];
      if (i > int'(pos) + 1) above_nxt = above_nxt | pending[i];
      if (i < int'(pos))     below     = below     | pending[i];
      if (i < int'(pos) - 1) below_nxt = below_nxt | pending[i];
    end
  end

endmodule

// File: rtl/elevator_ctrl.sv
// Single-car elevator controller: directional sweep scheduler, position
// tracking from landing sensors, and door dwell timer.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter  int NUM_FLOORS  = 3,
  parameter  int DOOR_CYCLES = 4,
  localparam int FW          = floor_w(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] floor_sensor,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic [NUM_FLOORS-1:0] hall_up,
  input  logic [NUM_FLOORS-1:0] hall_dn,
  output logic [1:0]            ac,
  output logic [FW-1:0]         display,
  output logic                  doorOpen,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int              CW       = $clog2(DOOR_CYCLES + 1);
  localparam logic [FW-1:0]   TOP      = FW'(NUM_FLOORS - 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(DOOR_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(1);

  state_t                state, state_d;
  dir_t                  dir, dir_d;
  logic [FW-1:0]         pos, pos_d, pos_up, pos_dn;
  logic [CW-1:0]         cnt, cnt_d;
  logic [NUM_FLOORS-1:0] at_pos, at_up, at_dn;
  logic [NUM_FLOORS-1:0] car_q, up_q, dn_q, clr_car, clr_up, clr_dn;
  logic                  above, below, here, above_nxt, below_nxt, press_here;
  logic                  door, svc_up, arrive_up, arrive_dn, stop_up, stop_dn;

  elevator_req_bank #(.NUM_FLOORS(NUM_FLOORS), .FW(FW)) u_bank (
    .clk        (clk),
    .rst        (rst),
    .car_req    (car_req),
    .hall_up    (hall_up),
    .hall_dn    (hall_dn),
    .pos        (pos),
    .door_open  (door),
    .clr_car    (clr_car),
    .clr_up     (clr_up),
    .clr_dn     (clr_dn),
    .car_q      (car_q),
    .up_q       (up_q),
    .dn_q       (dn_q),
    .pending    (pending),
    .above      (above),
    .below      (below),
    .here       (here),
    .above_nxt  (above_nxt),
    .below_nxt  (below_nxt),
    .press_here (press_here)
  );

  assign door    = (state == DOOR_OPEN);
  assign pos_up  = pos + 1'b1;
  assign pos_dn  = pos - 1'b1;
  assign at_pos  = NUM_FLOORS'(1) << pos;
  assign at_up   = NUM_FLOORS'(1) << pos_up;
  assign at_dn   = NUM_FLOORS'(1) << pos_dn;
  assign display = pos;

  // Keep the current heading while calls remain ahead of it, else turn.
  assign svc_up  = (dir == DIR_UP) ? above : !below;

  // Only the next landing in the direction of travel counts as arrival.
  assign arrive_up = (pos != TOP) && |(floor_sensor & at_up);
  assign arrive_dn = (pos != '0)  && |(floor_sensor & at_dn);
  assign stop_up   = |((car_q | up_q) & at_up) || !above_nxt || (pos_up == TOP);
  assign stop_dn   = |((car_q | dn_q) & at_dn) || !below_nxt || (pos_dn == '0);

  // State, position, heading and door timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pos   <= '0;
      dir   <= DIR_UP;
      cnt   <= '0;
    end else begin
      state <= state_d;
      pos   <= pos_d;
      dir   <= dir_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state: sweep scheduling, arrival handling and door dwell.
  always_comb begin
    state_d = state;
    pos_d   = pos;
    dir_d   = dir;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (here) begin
          state_d = DOOR_OPEN;
          cnt_d   = CNT_LOAD;
        end else if (above && (dir == DIR_UP || !below)) begin
          state_d = MOVE_UP;
          dir_d   = DIR_UP;
        end else if (below) begin
          state_d = MOVE_DOWN;
          dir_d   = DIR_DOWN;
        end
      end
      MOVE_UP: begin
        if (arrive_up) begin
          pos_d = pos_up;
          if (stop_up) begin
            state_d = DOOR_OPEN;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      MOVE_DOWN: begin
        if (arrive_dn) begin
          pos_d = pos_dn;
          if (stop_dn) begin
            state_d = DOOR_OPEN;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      DOOR_OPEN: begin
        dir_d = svc_up ? DIR_UP : DIR_DOWN;
        if (press_here) begin
          cnt_d = CNT_LOAD;
        end else if (cnt == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Calls served while the door is open at the current landing.
  always_comb begin
    clr_car = '0;
    clr_up  = '0;
    clr_dn  = '0;
    if (door) begin
      clr_car = at_pos;
      if (pos == TOP)      clr_dn = at_pos;
      else if (pos == '0)  clr_up = at_pos;
      else if (svc_up)     clr_up = at_pos;
      else                 clr_dn = at_pos;
    end
  end

  // Outputs decoded from the state register.
  always_comb begin
    ac       = AC_STOP;
    doorOpen = 1'b0;
    case (state)
      MOVE_UP:   ac       = AC_UP;
      MOVE_DOWN: ac       = AC_DOWN;
      DOOR_OPEN: doorOpen = 1'b1;
      default:   ac       = AC_STOP;
    endcase
  end

endmodule
